pc_reg: RTL and testbench
=========================

PC_REG -- requirements
Module: pc_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the program counter.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, value loaded into the PC on reset.
REQ-003 Port clk, input, 1, single rising-edge clock for all state.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port pc_in, input, XLEN, next-PC value supplied by the fetch/next-PC logic.
REQ-006 Port en, input, 1, load enable; 0 = stall (hold current PC).
REQ-007 Port pc_out, output, XLEN, current registered program counter.
REQ-008 Port pc_plus4, output, XLEN, combinational pc_out + 4.
REQ-009 Port pc_valid, output, 1, registered; 0 during reset, 1 from the first rising edge after reset release.
REQ-010 Port misaligned, output, 1, combinational; 1 when pc_out[1:0] != 2'b00.

Function
REQ-011 On a rising clk edge with rst_n = 1 and en = 1, pc_out SHALL take pc_in; latency one cycle, no bypass.
REQ-012 On a rising clk edge with rst_n = 1 and en = 0, pc_out SHALL hold its value.
REQ-013 pc_in SHALL be loaded unmodified, with no alignment masking; alignment is reported only via misaligned.
REQ-014 pc_plus4 SHALL be pc_out + 4 modulo 2^XLEN, with no carry out (0xFFFF_FFFC -> 0x0000_0000).
REQ-015 misaligned and pc_plus4 SHALL update combinationally from pc_out, with no added latency.
REQ-016 pc_valid SHALL rise on the first rising edge with rst_n = 1, independent of en, and remain 1 until the next reset.
REQ-017 pc_in SHALL be sampled only at the clock edge; changes between edges SHALL NOT affect pc_out.
REQ-018 All outputs SHALL be free of X once reset has been applied, regardless of X on pc_in while en = 0.

Reset
REQ-019 When rst_n = 0, pc_out SHALL become RESET_VECTOR immediately, without waiting for a clock edge.
REQ-020 When rst_n = 0, pc_valid SHALL become 0 immediately.
REQ-021 During reset, pc_plus4 SHALL equal RESET_VECTOR + 4 and misaligned SHALL reflect RESET_VECTOR[1:0].
REQ-022 Reset SHALL dominate en and pc_in on the same edge.
REQ-023 Reset asserted mid-operation SHALL discard the current PC.
REQ-024 Reset release SHALL be synchronous to clk externally; the block adds no synchronizer.

Structure
REQ-025 XLEN default, RESET_VECTOR default and the instruction-step constant 4 SHALL reside in the shared core package (riscv_pkg).
REQ-026 The block SHALL be a single flat module with no sub-modules: one always_ff for pc_out and pc_valid, plus continuous assigns.
REQ-027 All registers SHALL use a single always_ff sensitive to posedge clk and negedge rst_n.

Verification
REQ-028 Reset: hold rst_n = 0 for 10 ns with pc_in = 0x4 -> pc_out = 0x0000_0000, pc_valid = 0, pc_plus4 = 0x0000_0004.
REQ-029 Sequential load: release reset, en = 1, pc_in = 0x4, then 0x8, then 0xC on successive edges -> pc_out = 0x4, 0x8, 0xC, each one edge after being driven; pc_valid = 1.
REQ-030 Stall: pc_out = 0x8, en = 0, pc_in = 0x100 for 3 edges -> pc_out stays 0x8; re-assert en -> pc_out = 0x100 on the next edge.
REQ-031 Wrap and alignment: pc_in = 0xFFFF_FFFC loaded -> pc_plus4 = 0x0000_0000, misaligned = 0; pc_in = 0x0000_0006 loaded -> misaligned = 1.
REQ-032 Asynchronous reset: pc_out = 0xC, drop rst_n 2 ns after an edge -> pc_out = 0x0 and pc_valid = 0 before the next edge.
REQ-033 Same-edge priority: rst_n = 0 while en = 1 and pc_in = 0x40 -> pc_out remains RESET_VECTOR.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants: datapath width, reset vector and the fixed
// instruction step used by fetch-side logic.
package riscv_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int          PC_STEP              = 4;

endpackage : riscv_pkg

// File: rtl/pc_reg.sv
// Program counter register: loads pc_in when enabled, holds on stall, and
// exposes the sequential next PC, a misalignment flag and a valid flag.
module pc_reg
    import riscv_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic            en,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;
    logic            pc_valid_d;
    logic            pc_valid_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        if (en) begin
            pc_d = pc_in;
        end
    end

    // pc_in is never masked; alignment is only reported through misaligned.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample together.
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign pc_out     = pc_q;
    assign pc_plus4   = pc_q + XLEN'(PC_STEP);
    assign pc_valid   = pc_valid_q;
    assign misaligned = |pc_q[1:0];

endmodule : pc_reg

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed scenarios followed by random
// traffic compared against a simple behavioural PC model.
module tb_pc_reg;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        en;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_valid;

    pc_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_in      (pc_in),
        .en         (en),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .pc_valid   (pc_valid),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_out"},     pc_out,              m_pc);
        check({tag, ".pc_plus4"},   pc_plus4,            m_pc + 32'd4);
        check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, (m_pc % 4) != 0});
        check({tag, ".pc_valid"},   {31'd0, pc_valid},   {31'd0, m_valid});
    endtask

    // Asynchronous reset effect on the model, applied whenever rst_n is driven low.
    task automatic model_reset();
        m_pc    = RV;
        m_valid = 1'b0;
    endtask

    // Advance one rising edge, update the model from the sampled inputs, then settle.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_pc    = RV;
            m_valid = 1'b0;
        end else begin
            if (en) m_pc = pc_in;
            m_valid = 1'b1;
        end
        #1;
    endtask

    task automatic load(input logic [31:0] value);
        en    = 1'b1;
        pc_in = value;
        tick();
    endtask

    initial begin
        // Reset held for 10 ns with pc_in = 4
        rst_n = 1'b0;
        en    = 1'b1;
        pc_in = 32'h4;
        model_reset();
        #2;
        check_all("reset_early");
        #8;
        check_all("reset_10ns");

        // Release reset away from the rising edge, then sequential loads
        rst_n = 1'b1;
        load(32'h4);  check_all("seq_4");
        load(32'h8);  check_all("seq_8");
        load(32'hC);  check_all("seq_c");

        // Stall for three edges with a new pc_in pending
        load(32'h8);
        en    = 1'b0;
        pc_in = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("stall_hold");
        end
        en = 1'b1;
        tick();
        check_all("stall_release");

        // pc_in changes between edges must not disturb pc_out
        pc_in = 32'h200;
        #2;
        check_all("mid_cycle_1");
        pc_in = 32'h300;
        #1;
        check_all("mid_cycle_2");
        tick();
        check_all("mid_cycle_load");

        // X on pc_in while stalled must not reach any output
        en    = 1'b0;
        pc_in = 'x;
        tick();
        check_all("x_stall");
        tick();
        check_all("x_stall_2");

        // Wrap of pc_plus4 and misalignment reporting
        load(32'hFFFF_FFFC);
        check_all("wrap");
        check("wrap_plus4_zero", pc_plus4, 32'h0);
        load(32'h0000_0006);
        check_all("misalign_6");
        check("misalign_flag", {31'd0, misaligned}, 32'd1);
        load(32'h0000_0001);
        check_all("misalign_1");

        // Asynchronous reset dropped 2 ns after an edge
        load(32'hC);
        check_all("pre_async");
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");

        // Reset dominates en and pc_in on the same edge
        en    = 1'b1;
        pc_in = 32'h40;
        tick();
        check_all("reset_priority");

        // pc_valid rises on the first edge after release, even with en = 0
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        check_all("valid_no_en");

        // Random traffic with occasional mid-cycle resets
        for (int i = 0; i < 300; i++) begin
            en    = 1'($urandom_range(0, 3) != 0);
            pc_in = $urandom;
            if ($urandom_range(0, 31) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rand_async");
            end else begin
                rst_n = 1'b1;
            end
            tick();
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_reg
